// File: rtl/cog_vid_pkg.sv
// cog_vid_pkg: mode encodings and pixel shift helper for the cog video generator
package cog_vid_pkg;

    localparam logic [1:0] VID_1BPP = 2'b00;
    localparam logic [1:0] VID_2BPP = 2'b01;
    localparam logic [1:0] VID_8BPP = 2'b10;

    function automatic logic [3:0] vid_shift(input logic [1:0] mode);
        return (mode == VID_1BPP) ? 4'd1 : (mode == VID_8BPP) ? 4'd8 : 4'd2;
    endfunction

endpackage

// File: rtl/cog_vid_fifo.sv
// cog_vid_fifo: registered-output-free synchronous FIFO, no fall-through, full blocks push
module cog_vid_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              din,
    output logic [DW-1:0]              dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          push_ok, pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];
    assign level   = level_q;

    // storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

endmodule

// File: rtl/cog_vidx.sv
// cog_vidx: cog video generator - frame/pixel timing, pixel shifter, colour select, pin lane output
module cog_vidx
    import cog_vid_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PCLK_W = 8,
    parameter int FCLK_W = 12,
    parameter int PIN_W  = 32,
    localparam int GW    = (PIN_W / 8 > 1) ? $clog2(PIN_W / 8) : 1,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic              clk_vid,
    input  logic              res,
    input  logic              cfg_en,
    input  logic [1:0]        cfg_mode,
    input  logic [PCLK_W-1:0] cfg_pclks,
    input  logic [FCLK_W-1:0] cfg_fclks,
    input  logic [7:0]        cfg_border,
    input  logic [7:0]        cfg_mask,
    input  logic [GW-1:0]     cfg_group,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [31:0]       wr_pixel,
    input  logic [31:0]       wr_color,
    output logic [LW-1:0]     level,
    output logic              frame_done,
    output logic              underrun,
    input  logic              underrun_clr,
    output logic [PIN_W-1:0]  pin_out
);

    logic [FCLK_W-1:0] set_q, set_d;
    logic [PCLK_W-1:0] cnt_q, cnt_d;
    logic [31:0]       pixels_q, pixels_d, colors_q, colors_d, col_sh;
    logic [7:0]        discrete_q, discrete_d, sel;
    logic              frame_done_q, frame_done_d, underrun_q, underrun_d;
    logic              new_set, new_cnt, full, empty, pop;
    logic [63:0]       fifo_dout;
    logic [1:0]        idx;

    cog_vid_fifo #(.DEPTH(DEPTH), .DW(64)) u_fifo (
        .clk   (clk_vid),
        .rst   (res),
        .push  (wr_valid),
        .pop   (pop),
        .din   ({wr_pixel, wr_color}),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign wr_ready   = ~full;
    assign new_set    = (set_q == FCLK_W'(1));
    assign new_cnt    = (cnt_q == PCLK_W'(1));
    assign pop        = cfg_en & new_set & ~empty;
    assign idx        = (cfg_mode == VID_1BPP) ? {1'b0, pixels_q[0]} : pixels_q[1:0];
    assign col_sh     = colors_q >> {idx, 3'b000};
    assign sel        = (cfg_mode == VID_8BPP) ? pixels_q[7:0] : col_sh[7:0];
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;
    assign pin_out    = cfg_en ? (PIN_W'(discrete_q & cfg_mask) << {cfg_group, 3'b000}) : '0;

    // timing counters, frame load, pixel shift and colour select next-state
    always_comb begin
        set_d        = FCLK_W'(1);
        cnt_d        = PCLK_W'(1);
        pixels_d     = pixels_q;
        colors_d     = colors_q;
        discrete_d   = discrete_q;
        frame_done_d = 1'b0;
        underrun_d   = (cfg_en & new_set & empty) | (underrun_q & ~underrun_clr);
        if (cfg_en) begin
            set_d        = new_set ? cfg_fclks : set_q - FCLK_W'(1);
            cnt_d        = (new_set | new_cnt) ? cfg_pclks : cnt_q - PCLK_W'(1);
            frame_done_d = new_set;
            discrete_d   = sel;
            if (new_set) begin
                pixels_d = empty ? 32'd0 : fifo_dout[63:32];
                colors_d = empty ? {4{cfg_border}} : fifo_dout[31:0];
            end else if (new_cnt) begin
                pixels_d = pixels_q >> vid_shift(cfg_mode);
            end
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk_vid) begin
        if (res) begin
            set_q        <= FCLK_W'(1);
            cnt_q        <= PCLK_W'(1);
            pixels_q     <= '0;
            colors_q     <= '0;
            discrete_q   <= '0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            set_q        <= set_d;
            cnt_q        <= cnt_d;
            pixels_q     <= pixels_d;
            colors_q     <= colors_d;
            discrete_q   <= discrete_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

endmodule
